// File: rtl/fp_divider_param.sv
// Parametrised multi-cycle floating-point divider (out = DD / DS).
// Radix-2 restoring mantissa divider with start/busy/out_valid handshake,
// RNE or truncate rounding, flush-to-zero, and overflow/underflow flags.
module fp_divider_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int BIAS  = 127
) (
  input  logic                 control,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 rnd_mode,
  input  logic [EXP_W+MAN_W:0] DD,
  input  logic [EXP_W+MAN_W:0] DS,
  output logic                 busy,
  output logic                 out_valid,
  output logic [EXP_W+MAN_W:0] out,
  output logic                 exception,
  output logic                 zeroDiv,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int QW = MAN_W + 4;
  localparam int EW = EXP_W + 2;
  localparam int CW = $clog2(QW);
  localparam logic signed [EW-1:0] EMAX = EW'((2 ** EXP_W) - 1);

  typedef enum logic [2:0] {IDLE, SPECIAL, DIVIDE, NORM, ROUND} state_t;

  state_t                  state, nstate;
  logic [W-1:0]            a, b;
  logic                    rmode, sgn;
  logic signed [EW-1:0]    e;
  logic [MAN_W+1:0]        rem;
  logic [QW-1:0]           q;
  logic [CW-1:0]           cnt;
  logic [MAN_W-1:0]        frac;
  logic                    guard, sticky;

  logic [W-1:0]            opa, opb;
  logic                    a_nan, a_inf, a_zero, b_nan, b_inf, b_zero, is_special;
  logic [W-1:0]            sp_out;
  logic                    sp_exc, sp_zdiv;
  logic [MAN_W+1:0]        dvs, rem_nx;
  logic                    ge;
  logic                    inc, carry;
  logic [MAN_W-1:0]        fsum;
  logic signed [EW-1:0]    e_r;
  logic [W-1:0]            rnd_out;
  logic                    rnd_ovf, rnd_unf;

  assign busy = (state != IDLE);

  // Operand classification and special-case result; looks at the live inputs
  // while idle (to pick the path) and at the latched operands otherwise.
  always_comb begin
    opa = (state == IDLE) ? DD : a;
    opb = (state == IDLE) ? DS : b;
    a_zero = (opa[W-2:MAN_W] == '0);
    a_inf  = (opa[W-2:MAN_W] == '1) && (opa[MAN_W-1:0] == '0);
    a_nan  = (opa[W-2:MAN_W] == '1) && (opa[MAN_W-1:0] != '0);
    b_zero = (opb[W-2:MAN_W] == '0);
    b_inf  = (opb[W-2:MAN_W] == '1) && (opb[MAN_W-1:0] == '0);
    b_nan  = (opb[W-2:MAN_W] == '1) && (opb[MAN_W-1:0] != '0);
    is_special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
    sp_out  = {opa[W-1] ^ opb[W-1], {(W-1){1'b0}}};
    sp_exc  = 1'b0;
    sp_zdiv = 1'b0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      sp_out = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      sp_exc = 1'b1;
    end else if (b_zero && !a_inf) begin
      sp_out  = {opa[W-1] ^ opb[W-1], {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      sp_exc  = 1'b1;
      sp_zdiv = 1'b1;
    end else if (a_inf) begin
      sp_out = {opa[W-1] ^ opb[W-1], {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end
  end

  // One restoring-division step: subtract the divisor when it fits.
  always_comb begin
    dvs    = {1'b0, 1'b1, b[MAN_W-1:0]};
    ge     = (rem >= dvs);
    rem_nx = ge ? ((rem - dvs) << 1) : (rem << 1);
  end

  // Rounding, exponent range check and result packing.
  always_comb begin
    inc           = !rmode && guard && (sticky || frac[0]);
    {carry, fsum} = {1'b0, frac} + {{MAN_W{1'b0}}, inc};
    e_r           = e + $signed({{(EW-1){1'b0}}, carry});
    rnd_ovf       = 1'b0;
    rnd_unf       = 1'b0;
    rnd_out       = {sgn, e_r[EXP_W-1:0], fsum};
    if (!e_r[EW-1] && (e_r >= EMAX)) begin
      rnd_out = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      rnd_ovf = 1'b1;
    end else if (e_r[EW-1] || (e_r == '0)) begin
      rnd_out = {sgn, {(W-1){1'b0}}};
      rnd_unf = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge control or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nstate;
  end

  // Next-state sequencing.
  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (start) nstate = is_special ? SPECIAL : DIVIDE;
      SPECIAL: nstate = IDLE;
      DIVIDE:  if (cnt == CW'(QW - 1)) nstate = NORM;
      NORM:    nstate = ROUND;
      ROUND:   nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Datapath: operand latch, quotient accumulation, normalisation, result registers.
  always_ff @(posedge control or negedge reset) begin
    if (!reset) begin
      a <= '0; b <= '0; rmode <= 1'b0; sgn <= 1'b0; e <= '0;
      rem <= '0; q <= '0; cnt <= '0;
      frac <= '0; guard <= 1'b0; sticky <= 1'b0;
      out <= '0; out_valid <= 1'b0;
      exception <= 1'b0; zeroDiv <= 1'b0; overflow <= 1'b0; underflow <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: if (start) begin
          a     <= DD;
          b     <= DS;
          rmode <= rnd_mode;
          sgn   <= DD[W-1] ^ DS[W-1];
          e     <= {2'b00, DD[W-2:MAN_W]} - {2'b00, DS[W-2:MAN_W]} + EW'(BIAS);
          rem   <= {1'b0, 1'b1, DD[MAN_W-1:0]};
          q     <= '0;
          cnt   <= '0;
        end
        SPECIAL: begin
          out       <= sp_out;
          exception <= sp_exc;
          zeroDiv   <= sp_zdiv;
          overflow  <= 1'b0;
          underflow <= 1'b0;
          out_valid <= 1'b1;
        end
        DIVIDE: begin
          rem <= rem_nx;
          q   <= {q[QW-2:0], ge};
          cnt <= cnt + CW'(1);
        end
        NORM: begin
          // Both alignments are selected directly rather than shifting first,
          // so every quotient bit lands in fraction, guard or sticky.
          if (q[QW-1]) begin
            frac   <= q[QW-2:3];
            guard  <= q[2];
            sticky <= (rem != '0) | q[1] | q[0];
          end else begin
            frac   <= q[QW-3:2];
            guard  <= q[1];
            sticky <= (rem != '0) | q[0];
            e      <= e - EW'(1);
          end
        end
        ROUND: begin
          out       <= rnd_out;
          exception <= rnd_ovf;
          zeroDiv   <= 1'b0;
          overflow  <= rnd_ovf;
          underflow <= rnd_unf;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_divider_param.sv
// Self-checking bench for fp_divider_param: directed cases, reset abort,
// held-start behaviour, a half-precision instance and randomized operands
// compared with an arithmetic reference model.
module tb_fp_divider_param;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start, rnd_mode;
  logic [31:0] DD, DS, out_w;
  logic        busy, out_valid, exception, zeroDiv, overflow, underflow;

  logic        h_start, h_rm;
  logic [15:0] h_dd, h_ds, h_out;
  logic        h_busy, h_valid, h_exc, h_zdiv, h_ovf, h_unf;

  int errors = 0;
  int checks = 0;
  int lat, bc, vcount;
  logic [31:0] ra, rb;
  longint unsigned mr;
  logic [3:0] mfl;
  bit msp;

  fp_divider_param #(.EXP_W(8), .MAN_W(23), .BIAS(127)) dut (
    .control(clk), .reset(rst_n), .start(start), .rnd_mode(rnd_mode),
    .DD(DD), .DS(DS), .busy(busy), .out_valid(out_valid), .out(out_w),
    .exception(exception), .zeroDiv(zeroDiv), .overflow(overflow), .underflow(underflow)
  );

  fp_divider_param #(.EXP_W(5), .MAN_W(10), .BIAS(15)) dut_h (
    .control(clk), .reset(rst_n), .start(h_start), .rnd_mode(h_rm),
    .DD(h_dd), .DS(h_ds), .busy(h_busy), .out_valid(h_valid), .out(h_out),
    .exception(h_exc), .zeroDiv(h_zdiv), .overflow(h_ovf), .underflow(h_unf)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: exact integer quotient at guard precision, remainder as sticky.
  function automatic void ref_div(input longint unsigned a, input longint unsigned b,
                                  input int ew, input int mw, input bit rm,
                                  output longint unsigned r, output logic [3:0] fl,
                                  output bit sp);
    longint unsigned emx, fm, sa, sb, ea, eb, fa, fb, s, ma, mb, num, q, m;
    longint unsigned infv, zerov, nanv;
    longint e;
    int w, sh;
    bit an, bn, ai, bi, az, bz, g, st;
    w = 1 + ew + mw;
    emx = (64'd1 << ew) - 64'd1;
    fm  = (64'd1 << mw) - 64'd1;
    sa = (a >> (w - 1)) & 64'd1;  sb = (b >> (w - 1)) & 64'd1;
    ea = (a >> mw) & emx;         eb = (b >> mw) & emx;
    fa = a & fm;                  fb = b & fm;
    an = (ea == emx) && (fa != 0); ai = (ea == emx) && (fa == 0); az = (ea == 0);
    bn = (eb == emx) && (fb != 0); bi = (eb == emx) && (fb == 0); bz = (eb == 0);
    s = sa ^ sb;
    infv  = (s << (w - 1)) | (emx << mw);
    zerov = s << (w - 1);
    nanv  = (emx << mw) | (64'd1 << (mw - 1));
    sp = an | bn | ai | bi | az | bz;
    fl = 4'b0000;
    r  = zerov;
    if (an || bn || (az && bz) || (ai && bi)) begin r = nanv; fl = 4'b1000; end
    else if (bz && !ai) begin r = infv; fl = 4'b1100; end
    else if (ai) r = infv;
    else if (az || bi) r = zerov;
    else begin
      e  = longint'(ea) - longint'(eb) + longint'(emx >> 1);
      ma = (64'd1 << mw) | fa;
      mb = (64'd1 << mw) | fb;
      sh = (ma >= mb) ? mw + 1 : mw + 2;
      if (ma < mb) e--;
      num = ma << sh;
      q   = num / mb;
      st  = (num % mb) != 0;
      g   = q[0];
      m   = q >> 1;
      if (!rm && g && (st || m[0])) m++;
      if ((m >> (mw + 1)) != 0) begin m = m >> 1; e++; end
      if (e >= longint'(emx)) begin r = infv; fl = 4'b1010; end
      else if (e <= 0) begin r = zerov; fl = 4'b0001; end
      else r = (s << (w - 1)) | (longint'(e) << mw) | (m & fm);
    end
  endfunction

  task automatic wait_valid(output int l, output int bcnt);
    l = 0; bcnt = 0;
    while (out_valid !== 1'b1 && l < 100) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      l++;
    end
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic rm,
                       input string tag, input bit kchk, input logic [31:0] kout,
                       input logic [3:0] kfl);
    longint unsigned r;
    logic [3:0] fl;
    bit sp;
    int l, bcnt;
    ref_div(64'(a), 64'(b), 8, 23, rm, r, fl, sp);
    @(negedge clk);
    DD = a; DS = b; rnd_mode = rm; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; DD = $urandom; DS = $urandom; rnd_mode = 1'($urandom);
    wait_valid(l, bcnt);
    chk({tag, " latency"}, 64'(l), sp ? 64'd1 : 64'd29);
    chk({tag, " busy_cycles"}, 64'(bcnt), sp ? 64'd1 : 64'd29);
    chk({tag, " busy_at_valid"}, 64'(busy), 64'd0);
    chk({tag, " out"}, 64'(out_w), r);
    chk({tag, " flags"}, 64'({exception, zeroDiv, overflow, underflow}), 64'(fl));
    if (kchk) begin
      chk({tag, " out_const"}, 64'(out_w), 64'(kout));
      chk({tag, " flags_const"}, 64'({exception, zeroDiv, overflow, underflow}), 64'(kfl));
    end
    @(posedge clk); #1;
    chk({tag, " valid_pulse"}, 64'(out_valid), 64'd0);
    chk({tag, " out_hold"}, 64'(out_w), r);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; rnd_mode = 1'b0; DD = '0; DS = '0;
    h_start = 1'b0; h_rm = 1'b0; h_dd = '0; h_ds = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset valid", 64'(out_valid), 64'd0);
    chk("reset out", 64'(out_w), 64'd0);
    chk("reset flags", 64'({exception, zeroDiv, overflow, underflow}), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    do_op(32'h42356000, 32'h41400000, 1'b0, "t1", 1'b1, 32'h4071D555, 4'b0000);
    do_op(32'h3F800000, 32'h40400000, 1'b0, "third_rne", 1'b1, 32'h3EAAAAAB, 4'b0000);
    do_op(32'h3F800000, 32'h40400000, 1'b1, "third_trunc", 1'b1, 32'h3EAAAAAA, 4'b0000);
    do_op(32'h40C00000, 32'h00000000, 1'b0, "div_zero", 1'b1, 32'h7F800000, 4'b1100);
    do_op(32'h00000000, 32'h00000000, 1'b0, "zero_zero", 1'b1, 32'h7FC00000, 4'b1000);
    do_op(32'h7F000000, 32'h3E800000, 1'b0, "ovf", 1'b1, 32'h7F800000, 4'b1010);
    do_op(32'h00800000, 32'h40000000, 1'b0, "unf", 1'b1, 32'h00000000, 4'b0001);
    do_op(32'h7F800000, 32'h40000000, 1'b0, "inf_fin", 1'b1, 32'h7F800000, 4'b0000);
    do_op(32'h3F800000, 32'hFF800000, 1'b0, "fin_inf", 1'b1, 32'h80000000, 4'b0000);
    do_op(32'h7FC00001, 32'h3F800000, 1'b0, "nan_in", 1'b1, 32'h7FC00000, 4'b1000);
    do_op(32'hFF800000, 32'h7F800000, 1'b0, "inf_inf", 1'b1, 32'h7FC00000, 4'b1000);
    do_op(32'h00000001, 32'hBF800000, 1'b0, "denorm", 1'b1, 32'h80000000, 4'b0000);

    // Reset in the middle of DIVIDE aborts without a result.
    @(negedge clk);
    DD = 32'h42356000; DS = 32'h41400000; rnd_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    #2; rst_n = 1'b0; #1;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort out", 64'(out_w), 64'd0);
    chk("abort valid", 64'(out_valid), 64'd0);
    chk("abort flags", 64'({exception, zeroDiv, overflow, underflow}), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    vcount = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) vcount++;
    end
    chk("abort no_valid", 64'(vcount), 64'd0);
    do_op(32'h40800000, 32'h40000000, 1'b0, "after_rst", 1'b1, 32'h40000000, 4'b0000);

    // start held high: operands changed while busy are taken only after busy falls.
    @(negedge clk);
    DD = 32'h42356000; DS = 32'h41400000; rnd_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    DD = 32'h3F800000; DS = 32'h40400000;
    wait_valid(lat, bc);
    chk("held first latency", 64'(lat), 64'd29);
    chk("held first out", 64'(out_w), 64'h4071D555);
    @(posedge clk); #1;
    chk("held reaccept busy", 64'(busy), 64'd1);
    start = 1'b0;
    wait_valid(lat, bc);
    chk("held second latency", 64'(lat), 64'd29);
    chk("held second out", 64'(out_w), 64'h3EAAAAAB);

    // Half-precision instance: 5 / 2.
    @(negedge clk);
    h_dd = 16'h4500; h_ds = 16'h4000; h_rm = 1'b0; h_start = 1'b1;
    @(posedge clk); #1; h_start = 1'b0;
    lat = 0;
    while (h_valid !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    ref_div(64'h4500, 64'h4000, 5, 10, 1'b0, mr, mfl, msp);
    chk("half latency", 64'(lat), 64'd16);
    chk("half out", 64'(h_out), 64'h4100);
    chk("half model", 64'(h_out), mr);
    chk("half flags", 64'({h_exc, h_zdiv, h_ovf, h_unf}), 64'(mfl));

    // Randomized operands, biased toward normal, overflow and underflow ranges.
    for (int i = 0; i < 48; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 4))
        1, 2: begin ra[30:23] = 8'($urandom_range(100, 154)); rb[30:23] = 8'($urandom_range(100, 154)); end
        3:    begin ra[30:23] = 8'($urandom_range(190, 254)); rb[30:23] = 8'($urandom_range(1, 66)); end
        4:    begin ra[30:23] = 8'($urandom_range(1, 66)); rb[30:23] = 8'($urandom_range(190, 254)); end
        default: ;
      endcase
      do_op(ra, rb, 1'($urandom), "rand", 1'b0, 32'h0, 4'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
